// File: rtl/sfu_acc_bank.sv
// Multi-pass PSUM accumulation bank with ReLU/clamp output stage.
// Accumulates npass partial-sum vectors per output position, then emits one activated vector per position.

module sfu_acc_lane #(
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20
) (
    input  logic [PSUM_BW-1:0] psum,
    input  logic [ACC_BW-1:0]  base,
    input  logic               relu,
    output logic [ACC_BW-1:0]  sum,
    output logic [PSUM_BW-1:0] act
);
    localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic signed [ACC_BW-1:0] P_MAX   = {{(ACC_BW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] P_MIN   = {{(ACC_BW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};

    logic signed [ACC_BW:0]   wide;
    logic signed [ACC_BW-1:0] sat;
    logic signed [ACC_BW-1:0] rel;

    always_comb begin
        wide = $signed({base[ACC_BW-1], base})
             + $signed({{(ACC_BW+1-PSUM_BW){psum[PSUM_BW-1]}}, psum});
        // one guard bit is enough to detect overflow of a two-operand add
        if (wide[ACC_BW] != wide[ACC_BW-1])
            sat = wide[ACC_BW] ? ACC_MIN : ACC_MAX;
        else
            sat = wide[ACC_BW-1:0];
        rel = (relu && sat[ACC_BW-1]) ? '0 : sat;
        if (rel > P_MAX)
            act = P_MAX[PSUM_BW-1:0];
        else if (rel < P_MIN)
            act = P_MIN[PSUM_BW-1:0];
        else
            act = rel[PSUM_BW-1:0];
        sum = sat;
    end
endmodule

module sfu_acc_bank #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20,
    parameter int DEPTH   = 16,
    localparam int NW     = $clog2(DEPTH) + 1,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic [7:0]             cfg_npass,
    input  logic [NW-1:0]          cfg_nout,
    input  logic                   cfg_relu,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COL*PSUM_BW-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COL*PSUM_BW-1:0] out_data,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH} state_t;

    typedef struct packed {
        logic [7:0]    npass;
        logic [NW-1:0] nout;
        logic          relu;
    } cfg_t;

    state_t state_q, state_d;
    cfg_t   cfg_q, cfg_n;

    logic [PW-1:0] ptr_q;
    logic [7:0]    pass_q;
    logic          out_valid_q;
    logic          done_q, done_d;
    logic          last_pass, last_ptr, accept;

    logic [COL-1:0][PSUM_BW-1:0] in_lanes, act, out_q;
    logic [COL-1:0][ACC_BW-1:0]  base, sum;
    logic [COL-1:0][ACC_BW-1:0]  bank [DEPTH];

    always_comb begin
        cfg_n.npass = (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
        if (cfg_nout == '0)
            cfg_n.nout = NW'(1);
        else if (cfg_nout > NW'(DEPTH))
            cfg_n.nout = NW'(DEPTH);
        else
            cfg_n.nout = cfg_nout;
        cfg_n.relu = cfg_relu;
    end

    assign last_pass = (pass_q == cfg_q.npass - 8'd1);
    assign last_ptr  = (NW'(ptr_q) == cfg_q.nout - NW'(1));
    // only the last pass feeds the output register, so only it can stall
    assign in_ready  = (state_q == S_ACC) && (!last_pass || !out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign in_lanes  = in_data;
    assign base      = (pass_q == 8'd0) ? '0 : bank[ptr_q];

    for (genvar g = 0; g < COL; g++) begin : g_lane
        sfu_acc_lane #(.PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW)) u_lane (
            .psum (in_lanes[g]),
            .base (base[g]),
            .relu (cfg_q.relu),
            .sum  (sum[g]),
            .act  (act[g])
        );
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (cfg_start) state_d = S_ACC;
            S_ACC:   if (accept && last_pass && last_ptr) state_d = S_FLUSH;
            S_FLUSH: if (!out_valid_q || out_ready) begin
                         state_d = S_IDLE;
                         done_d  = 1'b1;
                     end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            cfg_q       <= '0;
            ptr_q       <= '0;
            pass_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == S_IDLE && cfg_start) begin
                cfg_q  <= cfg_n;
                ptr_q  <= '0;
                pass_q <= '0;
            end else if (accept) begin
                if (last_ptr) begin
                    ptr_q  <= '0;
                    pass_q <= pass_q + 8'd1;
                end else begin
                    ptr_q <= ptr_q + PW'(1);
                end
            end
            if (accept && last_pass) begin
                out_valid_q <= 1'b1;
                out_q       <= act;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // bank is scratch storage: every tile overwrites it on pass 0
    always_ff @(posedge clk) begin
        if (accept && !last_pass)
            bank[ptr_q] <= sum;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
endmodule

// File: tb/tb_sfu_acc_bank.sv
// Directed bench for sfu_acc_bank: activation, multi-pass sums, saturation, backpressure, abort, cfg handling.

module tb_sfu_acc_bank;
    localparam int COL = 8, PSUM_BW = 16, ACC_BW = 20, DEPTH = 16;
    localparam int NW = $clog2(DEPTH) + 1;
    localparam int W  = COL * PSUM_BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_start = 1'b0;
    logic [7:0]    cfg_npass = '0;
    logic [NW-1:0] cfg_nout = '0;
    logic          cfg_relu = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          done;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, ov_cnt = 0, done_cnt = 0, handoff_cyc = 0, done_cyc = 0;
    logic [W-1:0] q[$];

    sfu_acc_bank #(.COL(COL), .PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_npass(cfg_npass),
        .cfg_nout(cfg_nout), .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // observe handshakes just after the falling edge, once inputs have settled
    initial forever begin
        @(negedge clk);
        #2;
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
            q.push_back(out_data);
            handoff_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk2(input int a, input int b);
        logic [W-1:0] r;
        for (int k = 0; k < COL; k++)
            r[k*PSUM_BW +: PSUM_BW] = (k % 2 == 0) ? a[PSUM_BW-1:0] : b[PSUM_BW-1:0];
        return r;
    endfunction

    task automatic start(input int np, input int no, input logic r);
        cfg_npass = np[7:0];
        cfg_nout  = no[NW-1:0];
        cfg_relu  = r;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_cnt == prev && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (done_cnt == prev) begin
            n_fail++;
            $display("FAIL done_timeout done_cnt=%0d required>%0d", done_cnt, prev);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_relu_single;
        int qb = q.size(), d0 = done_cnt;
        start(1, 2, 1'b1);
        push(mk2(5, -3));
        push(mk2(-1, 7));
        wait_done(d0);
        n_checks++; if (q.size() != qb + 2) begin n_fail++; $display("FAIL relu_count got=%0d exp=%0d", q.size() - qb, 2); end
        n_checks++; if (q[qb] !== mk2(5, 0)) begin n_fail++; $display("FAIL relu_out0 got=%h exp=%h", q[qb], mk2(5, 0)); end
        n_checks++; if (q[qb+1] !== mk2(0, 7)) begin n_fail++; $display("FAIL relu_out1 got=%h exp=%h", q[qb+1], mk2(0, 7)); end
        n_checks++; if (done_cyc != handoff_cyc + 1) begin n_fail++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc, handoff_cyc + 1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL relu_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_multipass;
        int qb = q.size(), d0 = done_cnt, ovb = ov_cnt;
        start(9, 4, 1'b0);
        for (int i = 0; i < 32; i++) push(mk2(1, 1));
        n_checks++; if (ov_cnt != ovb) begin n_fail++; $display("FAIL mp_early_out_valid got=%0d exp=0", ov_cnt - ovb); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mp_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) push(mk2(1, 1));
        wait_done(d0);
        n_checks++; if (q.size() != qb + 4) begin n_fail++; $display("FAIL mp_count got=%0d exp=4", q.size() - qb); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q[qb+i] !== mk2(9, 9)) begin n_fail++; $display("FAIL mp_out%0d got=%h exp=%h", i, q[qb+i], mk2(9, 9)); end
        end
    endtask

    task automatic test_saturation;
        int qb = q.size(), d0 = done_cnt;
        start(2, 1, 1'b0);
        push(mk2(30000, 30000)); push(mk2(30000, 30000));
        wait_done(d0);
        n_checks++; if (q[qb] !== mk2(32767, 32767)) begin n_fail++; $display("FAIL sat_pos got=%h exp=%h", q[qb], mk2(32767, 32767)); end
        d0 = done_cnt;
        start(2, 1, 1'b0);
        push(mk2(-30000, -30000)); push(mk2(-30000, -30000));
        wait_done(d0);
        n_checks++; if (q[qb+1] !== mk2(-32768, -32768)) begin n_fail++; $display("FAIL sat_neg got=%h exp=%h", q[qb+1], mk2(-32768, -32768)); end
        // 17 x full-scale overruns the 20-bit accumulator; a wrap would flip the sign
        d0 = done_cnt;
        start(18, 1, 1'b0);
        for (int i = 0; i < 17; i++) push(mk2(-32768, 32767));
        push(mk2(0, 0));
        wait_done(d0);
        n_checks++; if (q[qb+2] !== mk2(-32768, 32767)) begin n_fail++; $display("FAIL sat_acc got=%h exp=%h", q[qb+2], mk2(-32768, 32767)); end
        d0 = done_cnt;
        start(1, 1, 1'b1);
        push(mk2(-30000, 200));
        wait_done(d0);
        n_checks++; if (q[qb+3] !== mk2(0, 200)) begin n_fail++; $display("FAIL sat_relu got=%h exp=%h", q[qb+3], mk2(0, 200)); end
    endtask

    task automatic test_backpressure;
        int qb = q.size(), d0 = done_cnt, c0;
        start(1, 4, 1'b0);
        out_ready = 1'b0;
        push(mk2(100, -200));
        in_valid = 1'b1;
        in_data  = mk2(101, -201);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d got=%b exp=0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_data !== mk2(100, -200)) begin
                n_fail++; $display("FAIL bp_hold c%0d got=%b/%h exp=1/%h", i, out_valid, out_data, mk2(100, -200)); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        c0 = cyc;
        push(mk2(101, -201)); push(mk2(102, -202)); push(mk2(103, -203));
        n_checks++; if (cyc - c0 != 3) begin n_fail++; $display("FAIL bp_throughput got=%0d exp=3", cyc - c0); end
        wait_done(d0);
        n_checks++; if (q.size() != qb + 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", q.size() - qb); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q[qb+i] !== mk2(100 + i, -200 - i)) begin n_fail++; $display("FAIL bp_out%0d got=%h exp=%h", i, q[qb+i], mk2(100 + i, -200 - i)); end
        end
    endtask

    task automatic test_reset_mid;
        int qb, d0;
        start(9, 2, 1'b0);
        for (int i = 0; i < 7; i++) push(mk2(1, 1));
        d0 = done_cnt;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_state busy=%b ov=%b ir=%b exp=0/0/0", busy, out_valid, in_ready); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%0d/%b exp=%0d/0", done_cnt, busy, d0); end
        qb = q.size();
        start(2, 2, 1'b0);
        push(mk2(3, 4)); push(mk2(5, 6)); push(mk2(10, -20)); push(mk2(1, 1));
        wait_done(d0);
        n_checks++; if (q[qb] !== mk2(13, -16)) begin n_fail++; $display("FAIL abort_fresh0 got=%h exp=%h", q[qb], mk2(13, -16)); end
        n_checks++; if (q[qb+1] !== mk2(6, 7)) begin n_fail++; $display("FAIL abort_fresh1 got=%h exp=%h", q[qb+1], mk2(6, 7)); end
    endtask

    task automatic test_cfg_ignore;
        int qb = q.size(), d0 = done_cnt;
        start(2, 2, 1'b0);
        push(mk2(1, 2));
        cfg_npass = 8'd1; cfg_nout = NW'(1); cfg_relu = 1'b1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        push(mk2(3, 4)); push(mk2(10, 20)); push(mk2(-5, -5));
        wait_done(d0);
        n_checks++; if (q.size() != qb + 2) begin n_fail++; $display("FAIL cfgign_count got=%0d exp=2", q.size() - qb); end
        n_checks++; if (q[qb] !== mk2(11, 22)) begin n_fail++; $display("FAIL cfgign_out0 got=%h exp=%h", q[qb], mk2(11, 22)); end
        n_checks++; if (q[qb+1] !== mk2(-2, -1)) begin n_fail++; $display("FAIL cfgign_out1 got=%h exp=%h", q[qb+1], mk2(-2, -1)); end
        n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL cfgign_done got=%0d exp=%0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_cfg_limits;
        int qb = q.size(), d0 = done_cnt;
        start(0, 0, 1'b0);
        push(mk2(-7, 8));
        wait_done(d0);
        n_checks++; if (q.size() != qb + 1 || q[qb] !== mk2(-7, 8)) begin
            n_fail++; $display("FAIL zero_cfg got=%0d/%h exp=1/%h", q.size() - qb, q[qb], mk2(-7, 8)); end
        qb = q.size(); d0 = done_cnt;
        start(1, 31, 1'b0);
        for (int i = 0; i < 16; i++) push(mk2(i, -i));
        wait_done(d0);
        n_checks++; if (q.size() != qb + 16) begin n_fail++; $display("FAIL nout_clamp_count got=%0d exp=16", q.size() - qb); end
        n_checks++; if (q[qb+15] !== mk2(15, -15)) begin n_fail++; $display("FAIL nout_clamp_last got=%h exp=%h", q[qb+15], mk2(15, -15)); end
    endtask

    initial begin
        test_reset;
        test_relu_single;
        test_multipass;
        test_saturation;
        test_backpressure;
        test_reset_mid;
        test_cfg_ignore;
        test_cfg_limits;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
